decryption_block: RTL and testbench

DECRYPTION_BLOCK -- requirements
Module: decryption_block

---
 rtl/stream_cipher_pkg.sv | 14 +
 rtl/byte_fifo.sv | 47 ++++
 rtl/decryption_block.sv | 104 ++++++++++
 tb/tb_decryption_block.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_cipher_pkg.sv
// Shared types and default sizing for the stream-cipher decryption path.
package stream_cipher_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StOut
  } state_e;

  localparam int unsigned DefFifoDepth   = 4;
  localparam int unsigned DefHashTimeout = 64;

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide circular FIFO with synchronous active-high reset; depth must be a power of two.
module byte_fifo #(
  parameter int unsigned Depth = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  logic [7:0] data_i,
  input  logic       pop_i,
  output logic [7:0] head_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = PtrW + 1;

  logic [7:0]      mem_q [Depth];
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0] cnt_q;
  logic            do_push, do_pop;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/decryption_block.sv
// XORs queued ciphertext bytes with keystream bytes fetched one request at a time.
module decryption_block
  import stream_cipher_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = DefFifoDepth,
  parameter int unsigned HASH_TIMEOUT = DefHashTimeout
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [7:0] byte_in,
  input  logic       byte_in_pulse,
  output logic       request_byte_pulse,
  input  logic [7:0] hash_byte,
  input  logic       hash_byte_pulse,
  output logic [7:0] decrypted_byte,
  output logic       decrypted_byte_pulse,
  output logic       overflow,
  output logic       hash_timeout,
  output logic       busy
);

  localparam int unsigned TmoW = $clog2(HASH_TIMEOUT + 1);

  state_e          state_q, state_d;
  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [7:0]      dec_q, dec_d;
  logic            overflow_q, overflow_d;
  logic            hash_timeout_q, hash_timeout_d;
  logic            pop;
  logic            fifo_full, fifo_empty;
  logic [7:0]      fifo_head;

  byte_fifo #(
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk),
    .rst_i  (nrst),
    .push_i (byte_in_pulse),
    .data_i (byte_in),
    .pop_i  (pop),
    .head_o (fifo_head),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  // Keystream is only consumed while waiting for it; strays elsewhere are ignored.
  assign pop = (state_q == StWait) && hash_byte_pulse;

  always_comb begin
    state_d        = state_q;
    tmo_cnt_d      = tmo_cnt_q;
    dec_d          = dec_q;
    hash_timeout_d = hash_timeout_q;
    overflow_d     = overflow_q | (byte_in_pulse && fifo_full && !pop);
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) state_d = StReq;
      end
      StReq: begin
        tmo_cnt_d = '0;
        state_d   = StWait;
      end
      StWait: begin
        if (hash_byte_pulse) begin
          dec_d   = fifo_head ^ hash_byte;
          state_d = StOut;
        end else if (tmo_cnt_q == TmoW'(HASH_TIMEOUT - 1)) begin
          hash_timeout_d = 1'b1;
          state_d        = StReq;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      StOut: begin
        state_d = fifo_empty ? StIdle : StReq;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      state_q        <= StIdle;
      tmo_cnt_q      <= '0;
      dec_q          <= 8'h00;
      overflow_q     <= 1'b0;
      hash_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      tmo_cnt_q      <= tmo_cnt_d;
      dec_q          <= dec_d;
      overflow_q     <= overflow_d;
      hash_timeout_q <= hash_timeout_d;
    end
  end

  assign request_byte_pulse   = (state_q == StReq);
  assign decrypted_byte_pulse = (state_q == StOut);
  assign decrypted_byte       = dec_q;
  assign overflow             = overflow_q;
  assign hash_timeout         = hash_timeout_q;
  assign busy                 = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_decryption_block.sv
// Self-checking bench for decryption_block: directed vectors, corner sequences, random round trip.
module tb_decryption_block;

  localparam int unsigned Depth = 4;
  localparam int unsigned Tmo   = 64;
  localparam int unsigned NRand = 40;

  logic       clk = 1'b0;
  logic       nrst = 1'b1;
  logic [7:0] byte_in = 8'h00;
  logic       byte_in_pulse = 1'b0;
  logic       request_byte_pulse;
  logic [7:0] hash_byte = 8'h00;
  logic       hash_byte_pulse = 1'b0;
  logic [7:0] decrypted_byte;
  logic       decrypted_byte_pulse;
  logic       overflow;
  logic       hash_timeout;
  logic       busy;

  decryption_block #(
    .FIFO_DEPTH  (Depth),
    .HASH_TIMEOUT(Tmo)
  ) dut (
    .clk                 (clk),
    .nrst                (nrst),
    .byte_in             (byte_in),
    .byte_in_pulse       (byte_in_pulse),
    .request_byte_pulse  (request_byte_pulse),
    .hash_byte           (hash_byte),
    .hash_byte_pulse     (hash_byte_pulse),
    .decrypted_byte      (decrypted_byte),
    .decrypted_byte_pulse(decrypted_byte_pulse),
    .overflow            (overflow),
    .hash_timeout        (hash_timeout),
    .busy                (busy)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [7:0]  ct;
    logic [7:0]  key;
    int unsigned delay;
    logic [7:0]  pt;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else passed++;
  endtask

  // Inputs are driven and Moore outputs sampled 1 time unit after each rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (request_byte_pulse) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
    check({name, " request seen"}, 32'(ok), 32'd1);
  endtask

  task automatic serve(input string name, input logic [7:0] key, input logic [7:0] exp);
    wait_req(name);
    cyc();
    hash_byte       = key;
    hash_byte_pulse = 1'b1;
    cyc();
    hash_byte_pulse = 1'b0;
    check({name, " out pulse"}, 32'(decrypted_byte_pulse), 32'd1);
    check({name, " out data"}, 32'(decrypted_byte), 32'(exp));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0] ov_ct  [5];
  logic [7:0] ov_key [5];
  logic [7:0] r_pt   [NRand];
  logic [7:0] r_key  [NRand];
  logic [7:0] r_ct   [NRand];
  int         extra;

  initial begin
    vecs[0] = '{ct: 8'hA5, key: 8'h3C, delay: 0,  pt: 8'h99};
    vecs[1] = '{ct: 8'h0F, key: 8'hFF, delay: 0,  pt: 8'hF0};
    vecs[2] = '{ct: 8'h00, key: 8'h00, delay: 1,  pt: 8'h00};
    vecs[3] = '{ct: 8'hFF, key: 8'h0F, delay: 2,  pt: 8'hF0};
    vecs[4] = '{ct: 8'h5A, key: 8'hA5, delay: 5,  pt: 8'hFF};
    vecs[5] = '{ct: 8'h12, key: 8'h34, delay: 0,  pt: 8'h26};
    vecs[6] = '{ct: 8'h80, key: 8'h01, delay: 3,  pt: 8'h81};
    vecs[7] = '{ct: 8'h7E, key: 8'h7E, delay: 10, pt: 8'h00};

    // Reset with a byte strobe held: the byte must not be stored.
    nrst          = 1'b1;
    byte_in       = 8'h77;
    byte_in_pulse = 1'b1;
    cyc(); cyc(); cyc();
    nrst          = 1'b0;
    byte_in_pulse = 1'b0;
    check("reset decrypted_byte", 32'(decrypted_byte), 32'h00);
    check("reset request pulse", 32'(request_byte_pulse), 32'd0);
    check("reset out pulse", 32'(decrypted_byte_pulse), 32'd0);
    check("reset overflow", 32'(overflow), 32'd0);
    check("reset hash_timeout", 32'(hash_timeout), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      extra += int'(request_byte_pulse);
      cyc();
    end
    check("byte during reset ignored", 32'(extra), 32'd0);

    // Directed vectors with exact latency checks.
    for (int v = 0; v < 8; v++) begin
      extra         = 0;
      byte_in       = vecs[v].ct;
      byte_in_pulse = 1'b1;
      cyc();
      byte_in_pulse = 1'b0;
      check($sformatf("vec%0d no req at N+1", v), 32'(request_byte_pulse), 32'd0);
      check($sformatf("vec%0d busy", v), 32'(busy), 32'd1);
      cyc();
      check($sformatf("vec%0d req at N+2", v), 32'(request_byte_pulse), 32'd1);
      cyc();
      for (int d = 0; d < int'(vecs[v].delay); d++) begin
        extra += int'(request_byte_pulse) + int'(decrypted_byte_pulse);
        cyc();
      end
      extra += int'(request_byte_pulse) + int'(decrypted_byte_pulse);
      hash_byte       = vecs[v].key;
      hash_byte_pulse = 1'b1;
      cyc();
      hash_byte_pulse = 1'b0;
      check($sformatf("vec%0d out pulse", v), 32'(decrypted_byte_pulse), 32'd1);
      check($sformatf("vec%0d out data", v), 32'(decrypted_byte), 32'(vecs[v].pt));
      cyc();
      check($sformatf("vec%0d pulse one cycle", v), 32'(decrypted_byte_pulse), 32'd0);
      check($sformatf("vec%0d data held", v), 32'(decrypted_byte), 32'(vecs[v].pt));
      check($sformatf("vec%0d stray events", v), 32'(extra), 32'd0);
      check($sformatf("vec%0d idle busy", v), 32'(busy), 32'd0);
    end

    // Overflow: five back-to-back pushes with keystream withheld.
    ov_ct  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    ov_key = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    check("overflow clear before", 32'(overflow), 32'd0);
    for (int i = 0; i < 5; i++) begin
      byte_in       = ov_ct[i];
      byte_in_pulse = 1'b1;
      cyc();
    end
    byte_in_pulse = 1'b0;
    check("overflow set", 32'(overflow), 32'd1);
    hash_byte       = ov_key[0];
    hash_byte_pulse = 1'b1;
    cyc();
    hash_byte_pulse = 1'b0;
    check("ovf0 out pulse", 32'(decrypted_byte_pulse), 32'd1);
    check("ovf0 out data", 32'(decrypted_byte), 32'(ov_ct[0] ^ ov_key[0]));
    for (int i = 1; i < 4; i++) serve($sformatf("ovf%0d", i), ov_key[i], ov_ct[i] ^ ov_key[i]);
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      extra += int'(request_byte_pulse) + int'(decrypted_byte_pulse);
    end
    check("dropped byte not emitted", 32'(extra), 32'd0);
    check("overflow sticky", 32'(overflow), 32'd1);
    check("overflow idle busy", 32'(busy), 32'd0);

    // Timeout: hold keystream for the full window, expect a re-request.
    check("hash_timeout clear before", 32'(hash_timeout), 32'd0);
    byte_in       = 8'h0F;
    byte_in_pulse = 1'b1;
    cyc();
    byte_in_pulse = 1'b0;
    wait_req("tmo first");
    extra = 0;
    for (int i = 0; i < int'(Tmo); i++) begin
      cyc();
      extra += int'(request_byte_pulse);
    end
    check("tmo no early re-request", 32'(extra), 32'd0);
    check("tmo flag not yet", 32'(hash_timeout), 32'd0);
    cyc();
    check("tmo re-request", 32'(request_byte_pulse), 32'd1);
    check("tmo flag set", 32'(hash_timeout), 32'd1);
    serve("tmo", 8'hFF, 8'hF0);

    // Stray keystream while idle.
    cyc();
    hash_byte       = 8'hAA;
    hash_byte_pulse = 1'b1;
    cyc();
    hash_byte_pulse = 1'b0;
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      extra += int'(request_byte_pulse) + int'(decrypted_byte_pulse);
      cyc();
    end
    check("stray no output", 32'(extra), 32'd0);
    check("stray busy", 32'(busy), 32'd0);
    check("stray data held", 32'(decrypted_byte), 32'hF0);
    check("hash_timeout sticky", 32'(hash_timeout), 32'd1);

    // Reset while waiting with three bytes queued.
    for (int i = 0; i < 3; i++) begin
      byte_in       = 8'hC0 + 8'(i);
      byte_in_pulse = 1'b1;
      cyc();
    end
    byte_in_pulse = 1'b0;
    check("rstw busy before", 32'(busy), 32'd1);
    nrst = 1'b1;
    cyc();
    nrst = 1'b0;
    check("rstw decrypted_byte", 32'(decrypted_byte), 32'h00);
    check("rstw overflow", 32'(overflow), 32'd0);
    check("rstw hash_timeout", 32'(hash_timeout), 32'd0);
    check("rstw busy", 32'(busy), 32'd0);
    hash_byte       = 8'h5C;
    hash_byte_pulse = 1'b1;
    cyc();
    hash_byte_pulse = 1'b0;
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      extra += int'(request_byte_pulse) + int'(decrypted_byte_pulse);
      cyc();
    end
    check("rstw no activity after", 32'(extra), 32'd0);
    check("rstw busy after", 32'(busy), 32'd0);

    // Random round trip against a queue-occupancy model of the block.
    begin
      int unsigned push_idx, hash_idx, out_idx, req_cnt, cd, occ, cycles;
      for (int i = 0; i < int'(NRand); i++) begin
        r_pt[i]  = 8'($urandom);
        r_key[i] = 8'($urandom);
        r_ct[i]  = r_pt[i] ^ r_key[i];
      end
      push_idx = 0; hash_idx = 0; out_idx = 0; req_cnt = 0; cd = 0; occ = 0; cycles = 0;
      while (out_idx < NRand && cycles < 4000) begin
        hash_byte_pulse = 1'b0;
        byte_in_pulse   = 1'b0;
        if (decrypted_byte_pulse) begin
          check($sformatf("rnd out%0d", out_idx), 32'(decrypted_byte), 32'(r_pt[out_idx]));
          out_idx++;
        end
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            hash_byte       = r_key[hash_idx];
            hash_byte_pulse = 1'b1;
            hash_idx++;
            occ--;
          end
        end
        if (request_byte_pulse) begin
          req_cnt++;
          cd = $urandom_range(4, 1);
        end
        if (push_idx < NRand && occ < Depth && ($urandom % 2) == 0) begin
          byte_in       = r_ct[push_idx];
          byte_in_pulse = 1'b1;
          push_idx++;
          occ++;
        end
        cyc();
        cycles++;
      end
      hash_byte_pulse = 1'b0;
      byte_in_pulse   = 1'b0;
      check("rnd all emitted", 32'(out_idx), 32'(NRand));
      check("rnd one request per byte", 32'(req_cnt), 32'(NRand));
      cyc(); cyc();
      check("rnd idle busy", 32'(busy), 32'd0);
      check("rnd no overflow", 32'(overflow), 32'd0);
      check("rnd no timeout", 32'(hash_timeout), 32'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
